// File: rtl/mac_vector_scheduler.sv
// mac_vector_scheduler: lets two requesters share one signed MAC, one dot-product
// vector at a time, with a round-robin grant per vector.
// Optional feature: define MAC_TIMEOUT_EN to enable the DRAIN watchdog
// (TIMEOUT_CYC cycles). Without it DRAIN waits indefinitely and res_err is 0.
module mac_vector_scheduler #(
    parameter int DW          = 8,
    parameter int RW          = 16,
    parameter int MAX_LEN     = 256,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic signed [DW-1:0] req0_a,
    input  logic signed [DW-1:0] req0_b,
    input  logic signed [DW-1:0] req1_a,
    input  logic signed [DW-1:0] req1_b,
    input  logic [1:0]           req_last,
    output logic [1:0]           req_ready,
    output logic signed [DW-1:0] mac_a,
    output logic signed [DW-1:0] mac_b,
    output logic                 mac_valid_in,
    output logic                 mac_clr,
    input  logic signed [RW-1:0] mac_f,
    input  logic                 mac_valid_out,
    output logic                 res_valid,
    output logic signed [RW-1:0] res_data,
    output logic                 res_id,
    output logic                 res_err,
    input  logic                 res_ready
);

    localparam int CW = $clog2(MAX_LEN) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  ptr_q, ptr_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         retired_q, retired_d;
    logic [1:0]            req_ready_q, req_ready_d;
    logic signed [DW-1:0]  mac_a_q, mac_a_d;
    logic signed [DW-1:0]  mac_b_q, mac_b_d;
    logic                  mac_valid_in_q, mac_valid_in_d;
    logic                  mac_clr_q, mac_clr_d;
    logic                  res_valid_q, res_valid_d;
    logic signed [RW-1:0]  res_data_q, res_data_d;
    logic                  res_id_q, res_id_d;

    // Element handshake and the granted requester's data
    logic                  hs;
    logic                  sel_last;
    logic signed [DW-1:0]  sel_a;
    logic signed [DW-1:0]  sel_b;

`ifdef MAC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  res_err_q, res_err_d;
`endif

    // Next-state and registered-output logic for the vector FSM
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        ptr_d          = ptr_q;
        issued_d       = issued_q;
        retired_d      = retired_q;
        mac_a_d        = mac_a_q;
        mac_b_d        = mac_b_q;
        mac_valid_in_d = 1'b0;
        res_valid_d    = res_valid_q;
        res_data_d     = res_data_q;
        res_id_d       = res_id_q;
`ifdef MAC_TIMEOUT_EN
        tmo_d          = tmo_q;
        res_err_d      = res_err_q;
`endif
        sel_a    = gnt_q ? req1_a : req0_a;
        sel_b    = gnt_q ? req1_b : req0_b;
        sel_last = req_last[gnt_q];
        hs       = req_ready_q[gnt_q] & req_valid[gnt_q];

        case (state_q)
            S_IDLE: begin
                // The pointer holder wins a tie, otherwise whoever is asking
                if (req_valid[ptr_q]) begin
                    gnt_d   = ptr_q;
                    state_d = S_CLR;
                end else if (req_valid[~ptr_q]) begin
                    gnt_d   = ~ptr_q;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                issued_d  = '0;
                retired_d = '0;
                state_d   = S_FEED;
            end
            S_FEED: begin
                if (mac_valid_out) retired_d = retired_q + CW'(1);
                if (hs) begin
                    mac_a_d        = sel_a;
                    mac_b_d        = sel_b;
                    mac_valid_in_d = 1'b1;
                    issued_d       = issued_q + CW'(1);
                    // A full-length vector ends even if req_last never came
                    if (sel_last || (issued_q == LAST_IDX)) begin
                        state_d = S_DRAIN;
`ifdef MAC_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (mac_valid_out) retired_d = retired_q + CW'(1);
                // Completion is by product count, never by a fixed delay
                if (retired_q == issued_q) begin
                    res_data_d  = mac_f;
                    res_id_d    = gnt_q;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
`ifdef MAC_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    res_data_d  = mac_f;
                    res_id_d    = gnt_q;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
`ifdef MAC_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                    ptr_d       = ~gnt_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready only toward the granted requester, and only while feeding
        req_ready_d = (state_d == S_FEED) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
        mac_clr_d   = (state_d == S_CLR);
    end

    // State and output registers; reset drops any in-flight vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            gnt_q          <= 1'b0;
            ptr_q          <= 1'b0;
            issued_q       <= '0;
            retired_q      <= '0;
            req_ready_q    <= '0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
            mac_valid_in_q <= 1'b0;
            mac_clr_q      <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_id_q       <= 1'b0;
`ifdef MAC_TIMEOUT_EN
            tmo_q          <= '0;
            res_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            ptr_q          <= ptr_d;
            issued_q       <= issued_d;
            retired_q      <= retired_d;
            req_ready_q    <= req_ready_d;
            mac_a_q        <= mac_a_d;
            mac_b_q        <= mac_b_d;
            mac_valid_in_q <= mac_valid_in_d;
            mac_clr_q      <= mac_clr_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            res_id_q       <= res_id_d;
`ifdef MAC_TIMEOUT_EN
            tmo_q          <= tmo_d;
            res_err_q      <= res_err_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_valid_in = mac_valid_in_q;
    assign mac_clr      = mac_clr_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_id       = res_id_q;
`ifdef MAC_TIMEOUT_EN
    assign res_err      = res_err_q;
`else
    // Constant 0 without the watchdog (expression is false for any legal limit)
    assign res_err      = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_mac_vector_scheduler.sv
// tb_mac_vector_scheduler: directed vectors against a behavioural MAC with a
// two-stage pipeline; expected sums are hand-computed constants.
module tb_mac_vector_scheduler;

    localparam int DW          = 8;
    localparam int RW          = 16;
    localparam int MAX_LEN     = 256;
    localparam int TIMEOUT_CYC = 64;
    localparam int LAT         = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 rv [2];
    logic                 rl [2];
    logic signed [DW-1:0] ra [2];
    logic signed [DW-1:0] rb [2];
    logic [1:0]           req_valid;
    logic [1:0]           req_last;
    logic [1:0]           req_ready;
    logic signed [DW-1:0] mac_a, mac_b;
    logic                 mac_valid_in, mac_clr;
    logic signed [RW-1:0] mac_f;
    logic                 mac_valid_out;
    logic                 res_valid;
    logic signed [RW-1:0] res_data;
    logic                 res_id, res_err;
    logic                 res_ready;
    logic                 mac_block;

    assign req_valid = {rv[1], rv[0]};
    assign req_last  = {rl[1], rl[0]};

    mac_vector_scheduler #(
        .DW(DW), .RW(RW), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid),
        .req0_a(ra[0]), .req0_b(rb[0]), .req1_a(ra[1]), .req1_b(rb[1]),
        .req_last(req_last), .req_ready(req_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_clr(mac_clr),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_err(res_err),
        .res_ready(res_ready)
    );

    // Behavioural MAC: products retire LAT+1 cycles after mac_valid_in
    logic [LAT-1:0]       pv;
    logic signed [RW-1:0] pp [LAT];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv            <= '0;
            for (int i = 0; i < LAT; i++) pp[i] <= '0;
            mac_f         <= '0;
            mac_valid_out <= 1'b0;
        end else begin
            pv    <= {pv[LAT-2:0], mac_valid_in};
            pp[0] <= mac_a * mac_b;
            for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
            mac_valid_out <= pv[LAT-1] & ~mac_block;
            if (mac_clr) mac_f <= '0;
            else if (pv[LAT-1] && !mac_block) mac_f <= mac_f + pp[LAT-1];
        end
    end

    // Pulse counters for clear and operand-valid strobes
    int clr_cnt = 0;
    int vin_cnt = 0;
    always @(posedge clk) begin
        if (mac_clr) clr_cnt++;
        if (mac_valid_in) vin_cnt++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input int id, input int a, input int b, input bit last, input string tag);
        int  waited = 0;
        bit  acc    = 1'b0;
        rv[id] = 1'b1;
        ra[id] = DW'(a);
        rb[id] = DW'(b);
        rl[id] = last;
        while (!acc && waited < 400) begin
            acc = req_ready[id];
            tick();
            waited++;
        end
        rv[id] = 1'b0;
        rl[id] = 1'b0;
        if (!acc) check_val({tag, " accept_timeout"}, 0, 1);
        else begin
            check_val({tag, " vin"}, int'(mac_valid_in), 1);
            check_val({tag, " mac_a"}, int'(mac_a), a);
        end
    endtask

    task automatic send_vec(input int id, input int n, input int a[4], input int b[4],
                            input int gap, input string tag);
        for (int i = 0; i < n; i++) begin
            send_elem(id, a[i], b[i], (i == n - 1), $sformatf("%s.e%0d", tag, i));
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (g == 0) begin
                        check_val({tag, " bubble_vin"}, int'(mac_valid_in), 0);
                        check_val({tag, " bubble_hold_a"}, int'(mac_a), a[i]);
                    end
                end
            end
        end
    endtask

    task automatic get_result(input int exp_id, input int exp_data, input string tag);
        int waited = 0;
        while (!res_valid && waited < 600) begin
            tick();
            waited++;
        end
        if (!res_valid) check_val({tag, " res_timeout"}, 0, 1);
        else begin
            $display("result %s: id=%0d data=%0d err=%0d", tag, res_id, res_data, res_err);
            check_val({tag, " res_id"}, int'(res_id), exp_id);
            check_val({tag, " res_data"}, int'(res_data), exp_data);
            check_val({tag, " res_err"}, int'(res_err), 0);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check_val({tag, " res_valid_drop"}, int'(res_valid), 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int c0, v0, k;
        reset     = 1'b0;
        res_ready = 1'b0;
        mac_block = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rl[i] = 1'b0; ra[i] = '0; rb[i] = '0;
        end
        repeat (3) tick();
        check_val("rst req_ready", int'(req_ready), 0);
        check_val("rst mac_clr", int'(mac_clr), 0);
        check_val("rst mac_valid_in", int'(mac_valid_in), 0);
        check_val("rst res_valid", int'(res_valid), 0);
        reset = 1'b1;
        tick();

        // 1: basic three-element vector
        c0 = clr_cnt; v0 = vin_cnt;
        send_vec(0, 3, '{1, 2, 3, 0}, '{4, 5, 6, 0}, 0, "t1");
        get_result(0, 32, "t1");
        check_val("t1 clr_pulses", clr_cnt - c0, 1);
        check_val("t1 vin_pulses", vin_cnt - v0, 3);

        // 2: negative operands with gaps in req_valid
        v0 = vin_cnt;
        send_vec(0, 2, '{-4, -3, 0, 0}, '{-2, 1, 0, 0}, 2, "t2");
        get_result(0, 5, "t2");
        check_val("t2 vin_pulses", vin_cnt - v0, 2);

        // 3: both requesters contend; round-robin alternates
        do_reset();
        fork
            send_vec(0, 2, '{1, 1, 0, 0}, '{2, 3, 0, 0}, 0, "t3a0");
            send_vec(1, 2, '{2, -1, 0, 0}, '{3, 4, 0, 0}, 0, "t3a1");
            begin
                get_result(0, 5, "t3a_first");
                get_result(1, 2, "t3a_second");
            end
        join
        fork
            send_vec(0, 2, '{3, 3, 0, 0}, '{3, 3, 0, 0}, 0, "t3b0");
            send_vec(1, 2, '{-1, -2, 0, 0}, '{5, 5, 0, 0}, 0, "t3b1");
            begin
                get_result(0, 18, "t3b_first");
                get_result(1, -15, "t3b_second");
            end
        join

        // 4: consumer back-pressure holds the result
        send_vec(0, 1, '{2, 0, 0, 0}, '{3, 0, 0, 0}, 0, "t4");
        rv[1] = 1'b1; ra[1] = 8'sd5; rb[1] = 8'sd5; rl[1] = 1'b1;
        k = 0;
        while (!res_valid && k < 100) begin
            tick();
            k++;
        end
        check_val("t4 res_valid_seen", int'(res_valid), 1);
        c0 = clr_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t4 hold_valid", int'(res_valid), 1);
            check_val("t4 hold_data", int'(res_data), 6);
            check_val("t4 hold_id", int'(res_id), 0);
            check_val("t4 ready_low", int'(req_ready), 0);
        end
        check_val("t4 no_clr", clr_cnt - c0, 0);
        rv[1] = 1'b0; rl[1] = 1'b0;
        get_result(0, 6, "t4");

        // 5: asynchronous reset in the middle of a vector
        send_elem(0, 1, 1, 1'b0, "t5.e0");
        send_elem(0, 2, 2, 1'b0, "t5.e1");
        #3;
        reset = 1'b0;
        #1;
        check_val("t5 async req_ready", int'(req_ready), 0);
        check_val("t5 async mac_valid_in", int'(mac_valid_in), 0);
        check_val("t5 async mac_a", int'(mac_a), 0);
        check_val("t5 async mac_clr", int'(mac_clr), 0);
        check_val("t5 async res_valid", int'(res_valid), 0);
        tick();
        reset = 1'b1;
        tick();
        send_vec(0, 1, '{7, 0, 0, 0}, '{-2, 0, 0, 0}, 0, "t5");
        get_result(0, -14, "t5");

`ifdef MAC_TIMEOUT_EN
        // 6: watchdog fires when products never retire
        mac_block = 1'b1;
        send_elem(0, 3, 3, 1'b1, "t6.e0");
        k = 0;
        while (!res_valid && k < 200) begin
            tick();
            k++;
        end
        check_val("t6 timeout_cycles", k, TIMEOUT_CYC);
        check_val("t6 res_err", int'(res_err), 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_val("t6 res_err_clear", int'(res_err), 0);
        mac_block = 1'b0;
        repeat (4) tick();
`endif

        // 7: full-length vector without req_last
        for (int i = 0; i < MAX_LEN; i++) begin
            send_elem(0, 127, 127, 1'b0, $sformatf("t7.e%0d", i));
            if (i == MAX_LEN - 2) check_val("t7 ready_before_max", int'(req_ready[0]), 1);
        end
        check_val("t7 ready_after_max", int'(req_ready[0]), 0);
        get_result(0, 256, "t7");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
